bitmap_fb_scanout_arbiter: RTL

Owns the single port of a 1-bpp framebuffer RAM: 160×120 pixels, 16-bit words, 1200 words. It schedules display prefetch reads just ahead of the beam and gives every remaining RAM cycle to one writer through a valid/ready handshake. It sits between the video sync generator, which supplies hpos/vpos/visible, and the top-level colour-truncation stage. It replaces a combinational pattern renderer with bitmap scanout.

---
 rtl/bitmap_fb_pkg.sv | 23 ++
 rtl/bitmap_pixel_shifter.sv | 68 ++++++
 rtl/bitmap_fb_scanout_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/bitmap_fb_pkg.sv
// Shared geometry constants, colours and arbiter state encoding for the
// 1-bpp framebuffer scanout path.
package bitmap_fb_pkg;

  localparam int unsigned H_VISIBLE     = 640;
  localparam int unsigned H_TOTAL       = 800;
  localparam int unsigned V_VISIBLE     = 480;
  localparam int unsigned V_TOTAL       = 525;
  localparam int unsigned FB_WORDS      = 1200;
  localparam int unsigned WORDS_PER_ROW = 10;
  localparam int unsigned FETCH_LEAD    = 4;

  localparam logic [23:0] FG_COLOR = 24'hFFFFFF;
  localparam logic [23:0] BG_COLOR = 24'h000000;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FETCH,
    CAPTURE
  } arb_state_e;

endpackage

// File: rtl/bitmap_pixel_shifter.sv
// Prefetch register, 16-bit pixel shift register and registered colour mux.
// One bitmap pixel spans 4 screen columns; one word spans 64 columns.
module bitmap_pixel_shifter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_hpos,
  input  logic [9:0]  i_vpos,
  input  logic        i_visible,
  input  logic        i_capture,
  input  logic [15:0] i_rdata,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_visible
);
  import bitmap_fb_pkg::*;

  logic [15:0] prefetch_q, prefetch_d;
  logic [15:0] shift_q, shift_d;
  logic [23:0] rgb_q, rgb_d;
  logic        vis_q;
  logic        load, shift, pixel;

  // Load/shift control, current pixel selection and colour mux.
  always_comb begin
    load  = (i_hpos[5:0] == 6'd0) && (i_hpos < 10'(H_VISIBLE)) &&
            (i_vpos < 10'(V_VISIBLE));
    shift = (i_hpos[1:0] == 2'd3);
    // On a load cycle the word is only entering the shift register, so the
    // first pixel is taken straight from the prefetch MSB to keep 1-cycle latency.
    pixel = load ? prefetch_q[15] : shift_q[15];

    prefetch_d = i_capture ? i_rdata : prefetch_q;

    shift_d = shift_q;
    if (load) begin
      shift_d = prefetch_q;
    end else if (shift) begin
      shift_d = {shift_q[14:0], 1'b0};
    end

    rgb_d = '0;
    if (i_visible) begin
      rgb_d = pixel ? FG_COLOR : BG_COLOR;
    end
  end

  // Pixel data and colour registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prefetch_q <= '0;
      shift_q    <= '0;
      rgb_q      <= '0;
      vis_q      <= 1'b0;
    end else begin
      prefetch_q <= prefetch_d;
      shift_q    <= shift_d;
      rgb_q      <= rgb_d;
      vis_q      <= i_visible;
    end
  end

  assign o_r       = rgb_q[23:16];
  assign o_g       = rgb_q[15:8];
  assign o_b       = rgb_q[7:0];
  assign o_visible = vis_q;

endmodule

// File: rtl/bitmap_fb_scanout_arbiter.sv
// Single-port framebuffer RAM owner: schedules display prefetch reads just
// ahead of the beam and hands every other RAM cycle to one valid/ready writer.
module bitmap_fb_scanout_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_hpos,
  input  logic [9:0]  i_vpos,
  input  logic        i_visible,
  input  logic        i_wr_valid,
  input  logic [10:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ready,
  output logic        o_wr_err,
  output logic [10:0] o_ram_addr,
  output logic        o_ram_we,
  output logic [15:0] o_ram_wdata,
  input  logic [15:0] i_ram_rdata,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic        o_visible
);
  import bitmap_fb_pkg::*;

  logic [9:0]  next_v, lead_h, fetch_v;
  logic        line_slot, wrap_slot, fetch_slot;
  logic [10:0] fetch_row, fetch_word, fetch_addr;
  logic        wr_addr_ok, capture;
  arb_state_e  state_q, state_d;

  // Fetch slot decode and fetch address generation (row*10 + word).
  always_comb begin
    next_v     = (i_vpos == 10'(V_TOTAL - 1)) ? '0 : i_vpos + 10'd1;
    lead_h     = i_hpos + 10'(FETCH_LEAD);
    line_slot  = (i_vpos < 10'(V_VISIBLE)) && (lead_h[5:0] == 6'd0) &&
                 (i_hpos < 10'(H_VISIBLE - 64));
    wrap_slot  = (i_hpos == 10'(H_TOTAL - FETCH_LEAD)) &&
                 (next_v < 10'(V_VISIBLE));
    fetch_slot = line_slot || wrap_slot;
    fetch_v    = wrap_slot ? next_v : i_vpos;
    fetch_row  = 11'(fetch_v >> 2);
    fetch_word = wrap_slot ? '0 : 11'(lead_h >> 6);
    fetch_addr = (fetch_row << 3) + (fetch_row << 1) + fetch_word;
  end

  // Arbiter next state and RAM port / handshake outputs.
  always_comb begin
    state_d     = IDLE;
    o_wr_ready  = 1'b0;
    o_wr_err    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    wr_addr_ok  = (i_wr_addr < 11'(FB_WORDS));
    if (!i_rst) begin
      if (fetch_slot) begin
        state_d    = FETCH;
        o_ram_addr = fetch_addr;
      end else begin
        o_wr_ready = 1'b1;
        if (state_q == FETCH) begin
          state_d = CAPTURE;
        end else if (i_wr_valid) begin
          state_d = WRITE;
        end
        // A writer may share the CAPTURE cycle; the RAM read already happened.
        if (i_wr_valid) begin
          o_ram_addr  = i_wr_addr;
          o_ram_wdata = i_wr_data;
          o_ram_we    = wr_addr_ok;
          o_wr_err    = !wr_addr_ok;
        end
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign capture = (state_d == CAPTURE);

  bitmap_pixel_shifter u_shifter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_hpos    (i_hpos),
    .i_vpos    (i_vpos),
    .i_visible (i_visible),
    .i_capture (capture),
    .i_rdata   (i_ram_rdata),
    .o_r       (o_r),
    .o_g       (o_g),
    .o_b       (o_b),
    .o_visible (o_visible)
  );

endmodule
